neuron_param_bank: RTL and testbench
====================================

# neuron_param_bank

Multi-neuron parameter store for the SNN core: a Wishbone slave holding one packed parameter record per neuron. It also provides a sequential fetch engine that loads one neuron's record into registered outputs for the compute datapath, plus a membrane-potential write-back port. It generalises the single-neuron parameter block to NUM_NEURONS records with configurable axon count and four weight classes. It adds write acknowledgement, address range checking and atomic output update.

## Interface
Parameters:
- NUM_NEURONS, 32: records stored; NIDX_W = $clog2(NUM_NEURONS).
- NUM_AXONS, 256: connection bits per neuron; multiple of 32.
- PARAM_BASE, 32'h3002_0000: byte address of neuron 0, word 0.
- WPN (localparam) = NUM_AXONS/32 + 2: words per record.

Ports (clock is `wb_clk_i`; reset is `wb_rst_i`, synchronous, active-high):
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone cycle, strobe, write
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge, reads and writes
- wbs_dat_o  out  32  read data
- fetch_start_i  in  1  start fetch of fetch_neuron_i
- fetch_neuron_i  in  NIDX_W  neuron index
- fetch_busy_o  out  1  fetch in progress
- fetch_done_o  out  1  one-cycle pulse; outputs updated
- fetch_err_o  out  1  one-cycle pulse; index out of range
- pot_we_i  in  1  potential write-back request
- pot_neuron_i  in  NIDX_W  target neuron
- pot_i  in  9  new potential, signed
- pot_ack_o  out  1  one-cycle pulse; write-back done
- connections_o  out  NUM_AXONS  fetched connections
- current_potential_o, reset_potential_o  out  9  signed
- weights_0_o..weights_3_o  out  2  signed
- leak_o, positive_threshold_o, negative_threshold_o  out  9  signed
- reset_mode_o  out  1

## Operation
- Word address: idx = (wbs_adr_i - PARAM_BASE) >> 2; adr[1:0] are ignored. Record n, word w is at idx = n*WPN + w.
- Record layout:
  - Words 0..WPN-3: connections, MSB first. Word 0 holds connections[NUM_AXONS-1 -: 32].
  - Word WPN-2: [31:23] current_potential, [22:14] reset_potential, [13:12] w0, [11:10] w1, [9:8] w2, [7:6] w3; other bits are stored but unused.
  - Word WPN-1: [31:23] leak, [22:14] pos_thr, [13:5] neg_thr, [4] reset_mode.
- Storage: one access per cycle (single port), modelled as a register array.
- Port priority per cycle: potential write-back > fetch read > Wishbone.
- Wishbone:
  - A request (cyc & stb & !ack) is serviced in the first cycle the port is free.
  - Writes apply the wbs_sel_i byte mask.
  - Out of range (adr < PARAM_BASE or idx >= NUM_NEURONS*WPN): the write is dropped, a read returns 0, and the transfer is still acked.
  - If cyc or stb drops before service, the request is abandoned with no access.
- Fetch FSM:
  - IDLE: a start with index < NUM_NEURONS goes to READ with word counter 0.
  - IDLE: a start with index >= NUM_NEURONS pulses fetch_err_o and stays in IDLE.
  - READ: each granted cycle reads word counter into shadow registers. Counter WPN-1 goes to DONE. When the port is lost to write-back, the counter holds.
  - DONE: shadow registers copy to all outputs at once; fetch_done_o pulses; return to IDLE.
  - fetch_start_i while busy is ignored.
- Write-back: replaces bits [31:23] of word WPN-2 of pot_neuron_i. An out-of-range neuron is dropped but still acked. A fetch read of the same word in the same cycle is stalled, so the fetch returns the new value.

## Timing
- Reset:
  - All storage is cleared to 0; the FSM returns to IDLE.
  - All outputs are 0, including data outputs, ack, done, err and busy.
  - Reset during a fetch or a Wishbone transfer aborts it with no ack.
- Wishbone:
  - Access at cycle T; wbs_ack_o and wbs_dat_o are valid at T+1.
  - Ack is forced low at T+2, giving a minimum of 2 cycles per transfer.
  - wbs_dat_o holds its value between reads.
- Fetch:
  - Start sampled at T; fetch_busy_o is high T+1..T+WPN.
  - Reads occur T+1..T+WPN with no stalls.
  - fetch_done_o and the new outputs appear at T+WPN+1, with busy low.
  - Each stall adds 1 cycle.
  - Outputs hold the last completed fetch; they never show a partial record.
- fetch_err_o asserts at T+1.
- pot_we_i sampled at T gives pot_ack_o at T+1. A sustained pot_we_i may starve the other two ports; the core guarantees gaps.

## Test plan
- Reset, then read base+0x48 (n1, w8) -> ack one cycle after access, data 0; all outputs 0.
- Write 32'hDEADBEEF to base+0x48 with sel=4'b0101, then read it back -> 32'h00AD00EF; ack returned for both write and read.
- Load neuron 2:
  - Stimulus: word 8 = 32'h8040_5AC0; word 9 = 32'hFF81_8E10; start fetch at T.
  - Required response: done at T+11; current_potential=-256; w0=1, w1=-2, w2=-2, w3=-1; leak=-1; reset_mode=1.
- pot_we_i for neuron 2 with pot_i=9'h07F during a neuron 2 fetch -> pot_ack_o the next cycle; fetch_done_o delayed by 1 cycle; current_potential_o=127.
- Read base+4*(NUM_NEURONS*WPN) and base-4 -> data 0, acked; a write to the same address changes no storage.
- fetch_neuron_i=NUM_NEURONS -> fetch_err_o pulse, busy stays low; assert wb_rst_i mid-fetch -> busy low next cycle, no done.

Source files
------------

// File: rtl/neuron_param_bank.sv
// neuron_param_bank: per-neuron parameter store with Wishbone access, record fetch engine and potential write-back
module neuron_param_bank #(
    parameter int NUM_NEURONS = 32,
    parameter int NUM_AXONS = 256,
    parameter logic [31:0] PARAM_BASE = 32'h3002_0000,
    parameter int NIDX_W = $clog2(NUM_NEURONS)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic                 fetch_start_i,
    input  logic [NIDX_W-1:0]    fetch_neuron_i,
    output logic                 fetch_busy_o,
    output logic                 fetch_done_o,
    output logic                 fetch_err_o,
    input  logic                 pot_we_i,
    input  logic [NIDX_W-1:0]    pot_neuron_i,
    input  logic [8:0]           pot_i,
    output logic                 pot_ack_o,
    output logic [NUM_AXONS-1:0] connections_o,
    output logic [8:0]           current_potential_o,
    output logic [8:0]           reset_potential_o,
    output logic [1:0]           weights_0_o,
    output logic [1:0]           weights_1_o,
    output logic [1:0]           weights_2_o,
    output logic [1:0]           weights_3_o,
    output logic [8:0]           leak_o,
    output logic [8:0]           positive_threshold_o,
    output logic [8:0]           negative_threshold_o,
    output logic                 reset_mode_o
);
    localparam int WPN = NUM_AXONS / 32 + 2;
    localparam int DEPTH = NUM_NEURONS * WPN;
    localparam int MW = $clog2(DEPTH);
    localparam int CW = $clog2(WPN);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NIDX_W-1:0]    nidx_q, nidx_d;
    logic [NUM_AXONS-1:0] conn_sh_q, conn_sh_d, conn_q, conn_d;
    logic [31:6]          w8_sh_q, w8_sh_d, w8_q, w8_d;
    logic [31:4]          w9_sh_q, w9_sh_d, w9_q, w9_d;
    logic                 ack_q, ack_d, err_q, err_d, pot_ack_q, pot_ack_d;
    logic [31:0]          dat_q, dat_d;
    logic [31:0]          mem_q [DEPTH];
    logic                 mem_we;
    logic [MW-1:0]        mem_widx, wb_idx, pot_idx, fetch_idx;
    logic [31:0]          mem_wdat, wb_off, rd;
    logic                 wb_ok, wb_grant, pot_ok, fetch_grant;

    // Port arbitration: write-back always wins, an active fetch blocks Wishbone
    always_comb begin
        wb_off      = wbs_adr_i - PARAM_BASE;
        wb_ok       = wbs_adr_i >= PARAM_BASE && (wb_off >> 2) < 32'(DEPTH);
        wb_idx      = MW'(wb_off >> 2);
        pot_ok      = 32'(pot_neuron_i) < NUM_NEURONS;
        pot_idx     = MW'(32'(pot_neuron_i) * WPN + WPN - 2);
        fetch_idx   = MW'(32'(nidx_q) * WPN + 32'(cnt_q));
        fetch_grant = state_q == READ && !pot_we_i;
        wb_grant    = wbs_cyc_i && wbs_stb_i && !ack_q && !pot_we_i && state_q != READ;
        rd          = mem_q[fetch_idx];
        ack_d       = wb_grant;
        pot_ack_d   = pot_we_i;
        dat_d       = (wb_grant && !wbs_we_i) ? (wb_ok ? mem_q[wb_idx] : '0) : dat_q;
        mem_we      = 1'b0;
        mem_widx    = pot_idx;
        mem_wdat    = {pot_i, mem_q[pot_idx][22:0]};
        if (pot_we_i) begin
            mem_we = pot_ok;
        end else if (wb_grant && wbs_we_i) begin
            mem_we   = wb_ok;
            mem_widx = wb_idx;
            for (int b = 0; b < 4; b++)
                mem_wdat[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : mem_q[wb_idx][8*b +: 8];
        end
    end

    // Fetch engine; outputs load from the next-shadow so the whole record lands with done
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nidx_d    = nidx_q;
        conn_sh_d = conn_sh_q;
        w8_sh_d   = w8_sh_q;
        w9_sh_d   = w9_sh_q;
        conn_d    = conn_q;
        w8_d      = w8_q;
        w9_d      = w9_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (fetch_start_i) begin
                if (32'(fetch_neuron_i) < NUM_NEURONS) begin
                    state_d = READ;
                    cnt_d   = '0;
                    nidx_d  = fetch_neuron_i;
                end else begin
                    err_d = 1'b1;
                end
            end
            READ: if (fetch_grant) begin
                for (int i = 0; i < WPN - 2; i++)
                    if (cnt_q == CW'(i)) conn_sh_d[NUM_AXONS-1-32*i -: 32] = rd;
                if (cnt_q == CW'(WPN - 2)) w8_sh_d = rd[31:6];
                if (cnt_q == CW'(WPN - 1)) begin
                    w9_sh_d = rd[31:4];
                    conn_d  = conn_sh_d;
                    w8_d    = w8_sh_d;
                    w9_d    = w9_sh_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nidx_q    <= '0;
            conn_sh_q <= '0;
            w8_sh_q   <= '0;
            w9_sh_q   <= '0;
            conn_q    <= '0;
            w8_q      <= '0;
            w9_q      <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            pot_ack_q <= 1'b0;
            dat_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nidx_q    <= nidx_d;
            conn_sh_q <= conn_sh_d;
            w8_sh_q   <= w8_sh_d;
            w9_sh_q   <= w9_sh_d;
            conn_q    <= conn_d;
            w8_q      <= w8_d;
            w9_q      <= w9_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            pot_ack_q <= pot_ack_d;
            dat_q     <= dat_d;
            if (mem_we) mem_q[mem_widx] <= mem_wdat;
        end
    end

    assign wbs_ack_o            = ack_q;
    assign wbs_dat_o            = dat_q;
    assign fetch_busy_o         = state_q == READ;
    assign fetch_done_o         = state_q == DONE;
    assign fetch_err_o          = err_q;
    assign pot_ack_o            = pot_ack_q;
    assign connections_o        = conn_q;
    assign current_potential_o  = w8_q[31:23];
    assign reset_potential_o    = w8_q[22:14];
    assign weights_0_o          = w8_q[13:12];
    assign weights_1_o          = w8_q[11:10];
    assign weights_2_o          = w8_q[9:8];
    assign weights_3_o          = w8_q[7:6];
    assign leak_o               = w9_q[31:23];
    assign positive_threshold_o = w9_q[22:14];
    assign negative_threshold_o = w9_q[13:5];
    assign reset_mode_o         = w9_q[4];
endmodule

// File: tb/tb_neuron_param_bank.sv
// tb_neuron_param_bank: randomized bench for neuron_param_bank against a word-array reference model
module tb_neuron_param_bank;
    localparam int NN = 20;
    localparam int NA = 256;
    localparam int WPN = NA / 32 + 2;
    localparam int DEPTH = NN * WPN;
    localparam logic [31:0] BASE = 32'h3002_0000;
    localparam int NW = $clog2(NN);

    logic clk = 1'b0, rst = 1'b1;
    logic cyc = 0, stb = 0, we = 0;
    logic [3:0] sel = 0;
    logic [31:0] adr = 0, wdat = 0, rdat;
    logic ack;
    logic fstart = 0, fbusy, fdone, ferr;
    logic [NW-1:0] fneuron = 0, pneuron = 0;
    logic pwe = 0, pack;
    logic [8:0] pval = 0;
    logic [NA-1:0] conn;
    logic [8:0] cur_pot, rst_pot, leak, pos_thr, neg_thr;
    logic [1:0] w0, w1, w2, w3;
    logic rmode;

    neuron_param_bank #(.NUM_NEURONS(NN), .NUM_AXONS(NA), .PARAM_BASE(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .fetch_start_i(fstart), .fetch_neuron_i(fneuron),
        .fetch_busy_o(fbusy), .fetch_done_o(fdone), .fetch_err_o(ferr),
        .pot_we_i(pwe), .pot_neuron_i(pneuron), .pot_i(pval), .pot_ack_o(pack),
        .connections_o(conn), .current_potential_o(cur_pot), .reset_potential_o(rst_pot),
        .weights_0_o(w0), .weights_1_o(w1), .weights_2_o(w2), .weights_3_o(w3),
        .leak_o(leak), .positive_threshold_o(pos_thr), .negative_threshold_o(neg_thr),
        .reset_mode_o(rmode)
    );

    always #5 clk = ~clk;

    logic [31:0] ref_mem [DEPTH];
    logic [NA-1:0] exp_conn = '0;
    logic [31:0] exp_w8 = '0, exp_w9 = '0;
    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [NA-1:0] got, input logic [NA-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a >= BASE && ((a - BASE) >> 2) < DEPTH;
    endfunction

    task automatic clear_model;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_conn = '0;
        exp_w8 = '0;
        exp_w9 = '0;
    endtask

    task automatic load_exp(input int n);
        for (int w = 0; w < WPN - 2; w++) exp_conn[NA-1-32*w -: 32] = ref_mem[n*WPN+w];
        exp_w8 = ref_mem[n*WPN+WPN-2];
        exp_w9 = ref_mem[n*WPN+WPN-1];
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_conn"}, conn, exp_conn);
        check({tag, "_cur_pot"}, cur_pot, exp_w8[31:23]);
        check({tag, "_rst_pot"}, rst_pot, exp_w8[22:14]);
        check({tag, "_weights"}, {w0, w1, w2, w3}, exp_w8[13:6]);
        check({tag, "_leak"}, leak, exp_w9[31:23]);
        check({tag, "_pos_thr"}, pos_thr, exp_w9[22:14]);
        check({tag, "_neg_thr"}, neg_thr, exp_w9[13:5]);
        check({tag, "_rmode"}, rmode, exp_w9[4]);
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int lat);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        do begin
            tick;
            lat++;
        end while (!ack && lat < 20);
        check("wb_ack", ack, 1'b1);
        r = rdat;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, a, d, s, r, lat);
        if (in_range(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[(a - BASE) >> 2][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic wb_read(input logic [31:0] a, input string tag);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b0, a, '0, '0, r, lat);
        check(tag, r, in_range(a) ? ref_mem[(a - BASE) >> 2] : 32'h0);
    endtask

    task automatic pot_apply(input int n, input logic [8:0] v);
        if (n < NN) ref_mem[n*WPN+WPN-2][31:23] = v;
    endtask

    task automatic pot_write(input int n, input logic [8:0] v);
        pwe = 1; pneuron = NW'(n); pval = v;
        tick;
        pwe = 0;
        check("pot_ack", pack, 1'b1);
        pot_apply(n, v);
        tick;
        check("pot_ack_pulse", pack, 1'b0);
    endtask

    // pot_k != 0 injects one write-back request k cycles into the fetch
    task automatic fetch(input int n, input int pot_k, input int pot_n, input logic [8:0] pot_v);
        int cnt;
        fstart = 1; fneuron = NW'(n);
        tick;
        fstart = 0;
        check("fetch_busy", fbusy, 1'b1);
        for (cnt = 1; cnt < 40; cnt++) begin
            if (cnt == 5) check("fetch_hold", conn, exp_conn);
            if (pot_k != 0 && cnt == pot_k + 1) begin
                check("pot_ack_fetch", pack, 1'b1);
                pwe = 0;
            end
            if (pot_k != 0 && cnt == pot_k) begin
                pwe = 1; pneuron = NW'(pot_n); pval = pot_v;
                pot_apply(pot_n, pot_v);
            end
            if (fdone) break;
            tick;
        end
        pwe = 0;
        check("fetch_latency", cnt, WPN + 1 + (pot_k != 0 ? 1 : 0));
        check("fetch_busy_done", fbusy, 1'b0);
        load_exp(n);
        check_outputs("fetch");
        tick;
        check("fetch_done_pulse", fdone, 1'b0);
    endtask

    initial begin
        logic [31:0] r, a;
        int lat, k, dcount;
        clear_model();
        repeat (3) tick;
        rst = 0;
        tick;
        check("rst_busy", fbusy, 1'b0);
        check("rst_done", fdone, 1'b0);
        check("rst_err", ferr, 1'b0);
        check("rst_ack", ack, 1'b0);
        check("rst_pot_ack", pack, 1'b0);
        check("rst_rdat", rdat, 32'h0);
        check_outputs("rst");

        wb_xfer(1'b0, BASE + 32'h48, '0, '0, r, lat);
        check("rd_latency", lat, 1);
        check("rd_after_rst", r, 32'h0);
        tick;
        check("ack_drop", ack, 1'b0);

        wb_write(BASE + 32'h48, 32'hDEAD_BEEF, 4'b0101);
        wb_read(BASE + 32'h48, "sel_model");
        wb_xfer(1'b0, BASE + 32'h48, '0, '0, r, lat);
        check("sel_mask", r, 32'h00AD_00EF);
        tick;
        check("rdat_hold", rdat, 32'h00AD_00EF);

        wb_write(BASE + 32'h70, 32'h8040_5AC0, 4'hF);
        wb_write(BASE + 32'h74, 32'hFF81_8E10, 4'hF);
        fetch(2, 0, 0, '0);
        check("n2_cur_pot", cur_pot, 9'h100);
        check("n2_weights", {w0, w1, w2, w3}, 8'b01_10_10_11);
        check("n2_leak", leak, 9'h1FF);
        check("n2_rmode", rmode, 1'b1);

        fetch(2, 3, 2, 9'h07F);
        check("wb_pot", cur_pot, 9'h07F);

        wb_read(BASE + 32'(4 * DEPTH), "oor_hi_rd");
        wb_read(BASE - 32'd4, "oor_lo_rd");
        wb_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
        wb_write(BASE - 32'd4, 32'hFFFF_FFFF, 4'hF);

        fstart = 1; fneuron = NW'(NN);
        tick;
        fstart = 0;
        check("err_pulse", ferr, 1'b1);
        check("err_busy", fbusy, 1'b0);
        tick;
        check("err_clear", ferr, 1'b0);
        check("err_busy2", fbusy, 1'b0);

        for (int i = 0; i < DEPTH; i++) wb_write(BASE + 32'(4 * i), $urandom, 4'hF);
        for (int it = 0; it < 150; it++) begin
            k = $urandom_range(0, 9);
            if (k < 4) begin
                a = BASE + 32'(4 * $urandom_range(0, DEPTH + 3)) + 32'($urandom_range(0, 3));
                wb_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else if (k < 7) begin
                a = BASE + 32'(4 * $urandom_range(0, DEPTH + 3)) + 32'($urandom_range(0, 3));
                wb_read(a, "rand_rd");
            end else if (k < 8) begin
                pot_write($urandom_range(0, (1 << NW) - 1), 9'($urandom));
            end else begin
                fetch($urandom_range(0, NN - 1), $urandom_range(0, 1) ? $urandom_range(1, 8) : 0,
                      $urandom_range(0, (1 << NW) - 1), 9'($urandom));
            end
        end
        for (int i = 0; i < DEPTH; i++) wb_read(BASE + 32'(4 * i), "sweep");

        fstart = 1; fneuron = NW'(3);
        tick;
        fstart = 0;
        repeat (3) tick;
        rst = 1;
        tick;
        rst = 0;
        check("rst_mid_busy", fbusy, 1'b0);
        dcount = 0;
        repeat (15) begin
            tick;
            if (fdone) dcount++;
        end
        check("rst_mid_no_done", dcount, 0);
        clear_model();
        check_outputs("rst_mid");
        wb_read(BASE + 32'h70, "rst_mid_mem");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
